// File: rtl/alpaca_ospfb_utils_pkg.sv
// Shared types and defaults for the oversampled PFB datapath.
// Frame geometry defaults, pointer width and phase-compensation FSM states.
package alpaca_ospfb_utils_pkg;

    localparam int FFT_LEN_DEFAULT = 64;
    localparam int DEC_FAC_DEFAULT = 48;
    localparam int WIDTH_DEFAULT   = 16;

    localparam int PTR_W = $clog2(FFT_LEN_DEFAULT);

    typedef enum logic {
        FILL,
        RUN
    } phasecomp_state_t;

endpackage

// File: rtl/phasecomp_buf_pingpong_ram.sv
// Two-bank simple dual-port RAM, address = {bank, ptr}.
// One-cycle registered read; read register clears on reset.
module pingpong_ram
    import alpaca_ospfb_utils_pkg::*;
#(
    parameter int AW    = PTR_W,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW:0]      waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW:0]      raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**(AW+1)];

    // Write port: storage array has no reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: registered, holds its value when not reading
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/phasecomp_buf.sv
// Phase-compensation ping-pong buffer between polyphase FIR and FFT.
// Optional debug port/assertion enabled by `PHASECOMP_DBG_EN.
module phasecomp_buf
    import alpaca_ospfb_utils_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEFAULT,
    parameter int DEC_FAC = DEC_FAC_DEFAULT,
    parameter int WIDTH   = WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_vld,
    output logic                       dout_sof
`ifdef PHASECOMP_DBG_EN
    ,
    output logic [$clog2(FFT_LEN)-1:0] shift_dbg
`endif
);

    localparam int AW = $clog2(FFT_LEN);
    localparam logic [AW:0]   M_W  = (AW+1)'(FFT_LEN);
    localparam logic [AW:0]   D_W  = (AW+1)'(DEC_FAC);
    localparam logic [AW-1:0] LAST = AW'(FFT_LEN - 1);

    phasecomp_state_t state;
    phasecomp_state_t state_nxt;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ctr;
    logic [AW-1:0] shift;
    logic          wr_bank;
    logic          wrap;
    logic          rd_go;
    logic [AW:0]   shift_sum;
    logic [AW:0]   shift_fix;
    logic [AW:0]   rd_sum;
    logic [AW:0]   rd_fix;

    assign wrap  = en && (wr_ptr == LAST);
    assign rd_go = en && (state == RUN);

    // Sums kept one bit wide so a non-dividing decimation wraps correctly
    assign shift_sum = {1'b0, shift} + D_W;
    assign shift_fix = (shift_sum >= M_W) ? shift_sum - M_W : shift_sum;
    assign rd_sum    = {1'b0, rd_ctr} + {1'b0, shift};
    assign rd_fix    = (rd_sum >= M_W) ? rd_sum - M_W : rd_sum;

    // FSM next state: leave FILL once the first frame is captured
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:    if (wrap) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = FILL;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_nxt;
    end

    // Pointers, bank select and rotation accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ctr  <= '0;
            wr_bank <= 1'b0;
            shift   <= '0;
        end else if (en) begin
            wr_ptr <= wrap ? '0 : wr_ptr + 1'b1;
            if (wrap) wr_bank <= ~wr_bank;
            if (state == RUN) begin
                rd_ctr <= wrap ? '0 : rd_ctr + 1'b1;
                if (wrap) shift <= shift_fix[AW-1:0];
            end
        end
    end

    pingpong_ram #(
        .AW    (AW),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (en),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (din),
        .re    (rd_go),
        .raddr ({~wr_bank, rd_fix[AW-1:0]}),
        .rdata (dout)
    );

    // Output strobes aligned with the registered read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_vld <= 1'b0;
            dout_sof <= 1'b0;
        end else begin
            dout_vld <= rd_go;
            dout_sof <= rd_go && (rd_ctr == '0);
        end
    end

`ifdef PHASECOMP_DBG_EN
    // Rotation applied to the read now on dout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       shift_dbg <= '0;
        else if (rd_go) shift_dbg <= shift;
    end

    shift_in_range: assert property (
        @(posedge clk) disable iff (!rst) ({1'b0, shift} < M_W)
    );
`endif

endmodule

// File: tb/tb_phasecomp_buf.sv
// Self-checking bench for phasecomp_buf (FFT_LEN=8, DEC_FAC=6).
// Covers `PHASECOMP_DBG_EN builds via the shift_dbg checks.
module phasecomp_buf_mon
    import alpaca_ospfb_utils_pkg::*;
#(
    parameter int AW = 3
) (
    input logic             clk,
    input logic             rst,
    input phasecomp_state_t state,
    input logic [AW-1:0]    wr_ptr,
    input logic [AW-1:0]    rd_ctr
);

    // Write and read counters move in lockstep while running
    always @(posedge clk) begin
        if (rst && state == RUN) begin
            assert (rd_ctr == wr_ptr)
            else $error("FAIL mon_lockstep rd_ctr=%0d wr_ptr=%0d", rd_ctr, wr_ptr);
        end
    end

endmodule

bind phasecomp_buf phasecomp_buf_mon #(.AW(AW)) u_mon (
    .clk    (clk),
    .rst    (rst),
    .state  (state),
    .wr_ptr (wr_ptr),
    .rd_ctr (rd_ctr)
);

module tb_phasecomp_buf;
    import alpaca_ospfb_utils_pkg::*;

    localparam int M = 8;
    localparam int D = 6;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         dout_vld;
    logic         dout_sof;
`ifdef PHASECOMP_DBG_EN
    logic [2:0]   shift_dbg;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         sof;
        logic [2:0]   shift;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] hist[$];
    int           n      = 0;
    bit           pend   = 0;
    int           checks = 0;
    int           passes = 0;

    always #5 clk = ~clk;

    phasecomp_buf #(
        .FFT_LEN (M),
        .DEC_FAC (D),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_sof  (dout_sof)
`ifdef PHASECOMP_DBG_EN
        ,
        .shift_dbg (shift_dbg)
`endif
    );

    // Drive one cycle; reference model predicts the output it causes
    task automatic drive(input logic e, input int d);
        exp_t x;
        int f, p, s;
        en   = e;
        din  = W'(d);
        pend = 0;
        if (e) begin
            hist.push_back(W'(d));
            if (n >= M) begin
                f = n / M - 1;
                p = n % M;
                s = (f * D) % M;
                x.data  = hist[f*M + (p + s) % M];
                x.sof   = (p == 0);
                x.shift = 3'(s);
                sbq.push_back(x);
                pend = 1;
            end
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        hist.delete();
        sbq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dout !== '0) $display("FAIL reset_dout: got %0d want 0", dout);
        else passes++;
        checks++;
        if (dout_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", dout_vld);
        else passes++;
        checks++;
        if (dout_sof !== 1'b0) $display("FAIL reset_sof: got %b want 0", dout_sof);
        else passes++;
`ifdef PHASECOMP_DBG_EN
        checks++;
        if (shift_dbg !== 3'd0) $display("FAIL reset_shift_dbg: got %0d want 0", shift_dbg);
        else passes++;
`endif
        rst = 1'b1;
        n = 0;
        hist.delete();
        sbq.delete();
    endtask

    task automatic test_frames();
        int tbl [24] = '{0, 1, 2, 3, 4, 5, 6, 7,
                         14, 15, 8, 9, 10, 11, 12, 13,
                         20, 21, 22, 23, 16, 17, 18, 19};
        exp_t x;
        int   j = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, i);
            if (pend) begin
                x = sbq.pop_front();
                checks++;
                if (dout_vld !== 1'b1 || dout !== x.data || dout_sof !== x.sof)
                    $display("FAIL frames[%0d]: vld=%b dout=%0d sof=%b want vld=1 dout=%0d sof=%b",
                             i, dout_vld, dout, dout_sof, x.data, x.sof);
                else passes++;
                checks++;
                if (dout !== W'(tbl[j]))
                    $display("FAIL frames_tbl[%0d]: dout=%0d want %0d", j, dout, tbl[j]);
                else passes++;
`ifdef PHASECOMP_DBG_EN
                checks++;
                if (shift_dbg !== x.shift)
                    $display("FAIL frames_shift[%0d]: got %0d want %0d", i, shift_dbg, x.shift);
                else passes++;
`endif
                j++;
            end else begin
                checks++;
                if (dout_vld !== 1'b0 || dout_sof !== 1'b0)
                    $display("FAIL fill_vld[%0d]: vld=%b sof=%b want 0 0", i, dout_vld, dout_sof);
                else passes++;
            end
        end
    endtask

    task automatic test_shift_wrap();
        int   stbl [8] = '{0, 6, 4, 2, 0, 6, 4, 2};
        exp_t x;
        int   vld_cnt = 0;
        int   sof_cnt = 0;
        do_reset();
        for (int i = 0; i < 8 + 8*M; i++) begin
            drive(1'b1, 100 + i);
            if (dout_vld === 1'b1) vld_cnt++;
            if (dout_sof === 1'b1) sof_cnt++;
            if (pend) begin
                x = sbq.pop_front();
                checks++;
                if (dout_vld !== 1'b1 || dout !== x.data || dout_sof !== x.sof)
                    $display("FAIL wrap[%0d]: vld=%b dout=%0d sof=%b want vld=1 dout=%0d sof=%b",
                             i, dout_vld, dout, dout_sof, x.data, x.sof);
                else passes++;
`ifdef PHASECOMP_DBG_EN
                checks++;
                if (shift_dbg !== 3'(stbl[(i - 8) / M]))
                    $display("FAIL wrap_shift[%0d]: got %0d want %0d",
                             i, shift_dbg, stbl[(i - 8) / M]);
                else passes++;
`else
                if (i == 8 + 8*M) $display("unreachable %0d", stbl[0]);
`endif
            end else begin
                checks++;
                if (dout_vld !== 1'b0)
                    $display("FAIL wrap_fill[%0d]: vld=%b want 0", i, dout_vld);
                else passes++;
            end
        end
        checks++;
        if (vld_cnt != 8*M) $display("FAIL wrap_vld_count: got %0d want %0d", vld_cnt, 8*M);
        else passes++;
        checks++;
        if (sof_cnt != 8) $display("FAIL wrap_sof_count: got %0d want 8", sof_cnt);
        else passes++;
    endtask

    task automatic test_stall();
        exp_t         x;
        logic [W-1:0] held;
        int           v = 0;
        do_reset();
        for (int i = 0; i < 19 + 3 + 21; i++) begin
            if (i >= 19 && i < 22) begin
                if (i == 19) held = dout;
                drive(1'b0, 9999);
                checks++;
                if (dout_vld !== 1'b0 || dout_sof !== 1'b0 || dout !== held)
                    $display("FAIL stall[%0d]: vld=%b sof=%b dout=%0d want 0 0 %0d",
                             i, dout_vld, dout_sof, dout, held);
                else passes++;
            end else begin
                drive(1'b1, v);
                v++;
                if (pend) begin
                    x = sbq.pop_front();
                    checks++;
                    if (dout_vld !== 1'b1 || dout !== x.data || dout_sof !== x.sof)
                        $display("FAIL stall_seq[%0d]: vld=%b dout=%0d sof=%b want vld=1 dout=%0d sof=%b",
                                 i, dout_vld, dout, dout_sof, x.data, x.sof);
                    else passes++;
                end else begin
                    checks++;
                    if (dout_vld !== 1'b0)
                        $display("FAIL stall_fill[%0d]: vld=%b want 0", i, dout_vld);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        do_reset();
        for (int i = 0; i < 11; i++) drive(1'b1, i + 1);
        sbq.delete();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dout !== '0 || dout_vld !== 1'b0 || dout_sof !== 1'b0)
            $display("FAIL async_reset: dout=%0d vld=%b sof=%b want 0 0 0",
                     dout, dout_vld, dout_sof);
        else passes++;
`ifdef PHASECOMP_DBG_EN
        checks++;
        if (shift_dbg !== 3'd0) $display("FAIL async_reset_shift: got %0d want 0", shift_dbg);
        else passes++;
`endif
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        hist.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 200 + i);
            if (pend) begin
                x = sbq.pop_front();
                checks++;
                if (dout_vld !== 1'b1 || dout !== x.data || dout_sof !== x.sof)
                    $display("FAIL post_reset[%0d]: vld=%b dout=%0d sof=%b want vld=1 dout=%0d sof=%b",
                             i, dout_vld, dout, dout_sof, x.data, x.sof);
                else passes++;
                if (i == 8) begin
                    checks++;
                    if (dout !== W'(200) || dout_sof !== 1'b1)
                        $display("FAIL post_reset_first: dout=%0d sof=%b want 200 1", dout, dout_sof);
                    else passes++;
                end
            end else begin
                checks++;
                if (dout_vld !== 1'b0)
                    $display("FAIL post_reset_fill[%0d]: vld=%b want 0", i, dout_vld);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_shift_wrap();
        test_stall();
        test_reset_mid();
        checks++;
        if (sbq.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sbq.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
